// File: rtl/vdp_pkg.sv
// Shared constants for the vdp99 CPU-side VRAM port: address width,
// control-port setup opcodes and FSM state encoding.
package vdp_pkg;

  localparam int VRAM_ADDR_W = 14;

  // Second control byte, bits [7:6]. Register writes match on bit 7 alone.
  localparam logic [1:0] SETUP_RD  = 2'b00;
  localparam logic [1:0] SETUP_WR  = 2'b01;
  localparam logic [1:0] SETUP_REG = 2'b1?;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_RDWAIT = 2'd2;

endpackage

// File: rtl/vdp_vram_port_addr_setup.sv
// Two-byte control-port address setup: first-byte flag, low-byte latch
// and opcode decode into address-load / prefetch strobes.
module vdp_addr_setup
  import vdp_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W
) (
  input  logic              pxclk,
  input  logic              reset,
  input  logic              wr0_tick,
  input  logic              rd0_tick,
  input  logic              wr1_tick,
  input  logic              rd1_tick,
  input  logic [7:0]        din,
  output logic              o_addr_load,
  output logic [ADDR_W-1:0] o_addr_new,
  output logic              o_prefetch
);

  logic       r_flag;
  logic [7:0] r_latch;
  logic       w_second;
  logic       w_is_addr;
  logic       w_is_rd;

  assign w_second   = wr1_tick & r_flag;
  assign o_addr_new = ADDR_W'({din[5:0], r_latch});

  always_comb begin
    w_is_addr = 1'b0;
    w_is_rd   = 1'b0;
    casez (din[7:6])
      SETUP_RD:  begin w_is_addr = 1'b1; w_is_rd = 1'b1; end
      SETUP_WR:  w_is_addr = 1'b1;
      SETUP_REG: ;
      default:   ;
    endcase
  end

  assign o_addr_load = w_second & w_is_addr;
  assign o_prefetch  = w_second & w_is_rd;

  always_ff @(posedge pxclk or posedge reset) begin
    if (reset) begin
      r_flag  <= 1'b0;
      r_latch <= 8'h00;
    end else if (wr1_tick) begin
      if (!r_flag) begin
        r_latch <= din;
        r_flag  <= 1'b1;
      end else begin
        r_flag  <= 1'b0;
      end
    end else if (wr0_tick | rd0_tick | rd1_tick) begin
      r_flag <= 1'b0;
    end
  end

endmodule

// File: rtl/vdp_vram_port.sv
// CPU-side VRAM access port: auto-incrementing address, read-ahead buffer
// and req/gnt handshake to the VRAM arbiter. Optional: VDP_OVERRUN_DET_EN.
module vdp_vram_port
  import vdp_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W
) (
  input  logic              pxclk,
  input  logic              reset,
  input  logic              wr0_tick,
  input  logic              rd0_tick,
  input  logic              wr1_tick,
  input  logic              rd1_tick,
  input  logic [7:0]        din,
  output logic [7:0]        rd_data,
  output logic              vram_req,
  input  logic              vram_gnt,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_wdata,
  input  logic [7:0]        vram_rdata,
  output logic              busy,
  output logic              overrun
);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              w_load;
  logic              w_pf;
  logic [ADDR_W-1:0] w_addr_new;
  logic [ADDR_W-1:0] w_addr_cur;
  logic              w_idle;
  logic              w_wr_go;
  logic              w_rd_go;
  logic              w_gnt;

  vdp_addr_setup #(.ADDR_W(ADDR_W)) u_setup (
    .pxclk       (pxclk),
    .reset       (reset),
    .wr0_tick    (wr0_tick),
    .rd0_tick    (rd0_tick),
    .wr1_tick    (wr1_tick),
    .rd1_tick    (rd1_tick),
    .din         (din),
    .o_addr_load (w_load),
    .o_addr_new  (w_addr_new),
    .o_prefetch  (w_pf)
  );

  assign w_idle  = (r_state == ST_IDLE);
  assign w_wr_go = w_idle & wr0_tick;
  assign w_rd_go = w_idle & ~wr0_tick & (rd0_tick | w_pf);
  assign w_gnt   = (r_state == ST_REQ) & vram_gnt;
  // A read-setup issues its prefetch at the address it is loading this cycle.
  assign w_addr_cur = w_load ? w_addr_new : r_addr;

  assign vram_req = (r_state == ST_REQ);
  assign busy     = ~w_idle;

  always_ff @(posedge pxclk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (w_wr_go | w_rd_go) r_state <= ST_REQ;
        ST_REQ:    if (vram_gnt) r_state <= vram_we ? ST_IDLE : ST_RDWAIT;
        ST_RDWAIT: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  // Grant increment lands on whatever address is current, including one
  // loaded by a setup that arrives in the grant cycle.
  always_ff @(posedge pxclk or posedge reset) begin
    if (reset) r_addr <= '0;
    else       r_addr <= w_addr_cur + ADDR_W'(w_gnt);
  end

  always_ff @(posedge pxclk or posedge reset) begin
    if (reset) begin
      vram_we    <= 1'b0;
      vram_addr  <= '0;
      vram_wdata <= 8'h00;
    end else if (w_wr_go) begin
      vram_we    <= 1'b1;
      vram_addr  <= w_addr_cur;
      vram_wdata <= din;
    end else if (w_rd_go) begin
      vram_we    <= 1'b0;
      vram_addr  <= w_addr_cur;
    end
  end

  always_ff @(posedge pxclk or posedge reset) begin
    if (reset)                     rd_data <= 8'h00;
    else if (r_state == ST_RDWAIT) rd_data <= vram_rdata;
  end

`ifdef VDP_OVERRUN_DET_EN
  logic w_drop;
  logic r_overrun;

  assign w_drop = (~w_idle & (wr0_tick | rd0_tick | w_pf)) |
                  (w_idle & wr0_tick & (rd0_tick | w_pf));

  always_ff @(posedge pxclk or posedge reset) begin
    if (reset)         r_overrun <= 1'b0;
    else if (w_drop)   r_overrun <= 1'b1;
    else if (rd1_tick) r_overrun <= 1'b0;
  end

  assign overrun = r_overrun;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: doc/vdp_vram_port.md
Name: vdp_vram_port

Overview:
- CPU-side VRAM access port for vdp99.
- Consumes the port-0 ticks (wr0_tick/rd0_tick) and the port-1 write ticks that carry the TMS9918-style two-byte address setup.
- Owns the 14-bit auto-incrementing VRAM address, the read-ahead buffer that drives vdp99 dout on port-0 reads, and a req/gnt handshake to the VRAM arbiter shared with display fetch.

Parameters:
- ADDR_W, 14, VRAM address width; address wraps modulo 2**ADDR_W.

Ports:
- pxclk  in  1  pixel clock, 25MHz; the only clock.
- reset  in  1  asynchronous, active-high reset.
- wr0_tick  in  1  one-cycle CPU write to data port.
- rd0_tick  in  1  one-cycle CPU read of data port.
- wr1_tick  in  1  one-cycle CPU write to control port.
- rd1_tick  in  1  one-cycle CPU read of status port; clears first-byte flag only.
- din  in  8  CPU write data.
- rd_data  out  8  read-ahead buffer; vdp99 drives dout from this on port-0 reads.
- vram_req  out  1  access request to arbiter.
- vram_gnt  in  1  one-cycle grant; the access is performed in the grant cycle.
- vram_we  out  1  1=write, 0=read; valid while vram_req.
- vram_addr  out  ADDR_W  access address; valid while vram_req.
- vram_wdata  out  8  write data; valid while vram_req.
- vram_rdata  in  8  read data; valid the cycle after gnt.
- busy  out  1  access outstanding (state != IDLE).
- overrun  out  1  sticky dropped-access flag (see Optional Feature).

Behaviour:
- Reset (async) values: addr=0, first-byte flag=0, latch=0, rd_data=0, state=IDLE, vram_req=0, vram_we=0, vram_addr=0, vram_wdata=0, overrun=0.
- Control port, first byte (flag=0): wr1_tick stores din in latch and sets flag=1.
- Control port, second byte (flag=1): wr1_tick clears flag.
  - din[7:6]=00: addr={din[5:0],latch}; read-prefetch issued.
  - din[7:6]=01: addr={din[5:0],latch}; no access.
  - din[7:6]=1x: register write owned by vdp_reg_ifce; addr unchanged, no access.
- wr0_tick, rd0_tick and rd1_tick all clear the flag.
- FSM states IDLE, REQ, RDWAIT:
  - IDLE, on wr0_tick: next cycle REQ, vram_we=1, vram_wdata=din, vram_addr=addr.
  - IDLE, on rd0_tick or read-setup: next cycle REQ, vram_we=0, vram_addr=addr.
  - REQ: vram_req=1 until vram_gnt. On gnt: a write goes to IDLE; a read goes to RDWAIT. addr increments on gnt, with wrap 0x3FFF->0x0000.
  - RDWAIT (one cycle): rd_data<=vram_rdata; go to IDLE.
- rd0_tick returns the current rd_data; the CPU sees the previously prefetched byte. The refill completes at least 3 cycles after the tick.
- A wr0/rd0/read-setup arriving while busy=1 is dropped: no VRAM access, no increment. A dropped access still performs its flag/addr-latch side effects, and overrun sets if enabled.
- Setup while busy: addr is overwritten immediately. The in-flight access keeps its captured vram_addr; its gnt increment applies to the new addr.
- Simultaneous wr0_tick and rd0_tick in IDLE: write wins; the read is treated as dropped.
- Reset mid-access: vram_req drops asynchronously; the pending access is abandoned.

Optional Feature:
- Macro VDP_OVERRUN_DET_EN.
- Defined: overrun sets on any dropped access and clears on rd1_tick (status read). If set and clear coincide, set wins.
- Undefined: overrun tied 0 and the related logic is removed; drops are silent.

Decomposition:
- Package vdp_pkg: ADDR_W default, setup opcode constants (SETUP_RD=2'b00, SETUP_WR=2'b01, SETUP_REG=2'b1x), FSM state encoding.
- One natural sub-module: vdp_addr_setup. It holds the first-byte flag, the latch and the opcode decode, and emits an addr_load strobe, the new address and a prefetch strobe. The FSM and datapath stay in the top.

Test Plan:
- Reset, wr1 0x34 then wr1 0x52 -> addr=0x1234, no vram_req. Then wr0 0xAA with gnt 2 cycles later -> vram_we=1, addr 0x1234, wdata 0xAA; addr becomes 0x1235.
- Read setup: wr1 0x00, wr1 0x10 -> prefetch at 0x1000. With rdata=0x5C, rd_data=0x5C and addr=0x1001. Then rd0 -> CPU sees 0x5C; next fetch at 0x1001.
- Wrap: setup write to 0x3FFF, wr0 twice (gnt each time) -> accesses at 0x3FFF then 0x0000.
- Flag reset: wr1 0x34, rd1_tick, wr1 0x56 -> 0x56 treated as first byte; no addr change.
- Overrun: hold gnt low, wr0 twice -> one access; with VDP_OVERRUN_DET_EN overrun=1 until rd1_tick, otherwise overrun=0.
- Reset asserted while in REQ -> vram_req=0 same cycle; rd_data=0 and addr=0 after release.
